// File: rtl/boot_ram.sv
// boot_ram: single-port CPU RAM with a streaming image loader and CPU reset control.
// The CPU is held in reset while an image streams into memory from address 0.
// After a successful load the reset is held for RST_CYC more cycles and then released.
// CPU writes to WATCH_ADDR are mirrored to watch_data, with a one-cycle watch_stb pulse.
// Optional feature: define BOOT_RAM_CHECKSUM_EN to enable the ld_sum load checksum.
module boot_ram #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned WATCH_ADDR = 100,
  parameter int unsigned RST_CYC    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [DATA_W-1:0] watch_data,
  output logic              watch_stb,
  output logic [DATA_W-1:0] ld_sum
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned REL_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_count, w_count_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [REL_W-1:0]  r_rel, w_rel_nxt;
  logic              r_cpu_rst, r_ld_ready;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_watch_data;
  logic              r_watch_stb;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [LEN_W-1:0]  w_len_sat;
  logic              w_hs;
  logic              w_last;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_watch_hit;

  // Requested length saturates at the memory depth so the write address never wraps.
  assign w_len_sat = (ld_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : ld_len;
  assign w_hs      = (r_state == S_LOAD) && ld_valid;
  assign w_last    = ({1'b0, r_count} == (r_len - LEN_W'(1)));

  // Next-state logic for the load / release / run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_len_nxt   = r_len;
    w_rel_nxt   = r_rel;
    case (r_state)
      S_HOLD, S_RUN: begin
        if (ld_start) begin
          w_len_nxt   = w_len_sat;
          w_count_nxt = '0;
          w_rel_nxt   = '0;
          w_state_nxt = (w_len_sat == '0) ? S_RELEASE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          w_count_nxt = r_count + ADDR_W'(1);
          if (w_last) begin
            w_rel_nxt   = '0;
            w_state_nxt = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (r_rel == REL_W'(RST_CYC - 1)) w_state_nxt = S_RUN;
        else                               w_rel_nxt   = r_rel + REL_W'(1);
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  // State register; cpu_rst and ld_ready are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HOLD;
      r_count    <= '0;
      r_len      <= '0;
      r_rel      <= '0;
      r_cpu_rst  <= 1'b1;
      r_ld_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_len      <= w_len_nxt;
      r_rel      <= w_rel_nxt;
      r_cpu_rst  <= (w_state_nxt != S_RUN);
      r_ld_ready <= (w_state_nxt == S_LOAD);
    end
  end

  // Single memory port: loader owns it in LOAD, CPU in RUN.
  assign w_mem_we    = w_hs || ((r_state == S_RUN) && cpu_we);
  assign w_mem_addr  = (r_state == S_LOAD) ? r_count : cpu_addr;
  assign w_mem_wdata = (r_state == S_LOAD) ? ld_data : cpu_wdata;

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Registered read-first CPU read data, zero outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_rdata <= '0;
    else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) r_rdata <= r_mem[w_mem_addr];
    else                                                r_rdata <= '0;
  end

  assign w_watch_hit = (r_state == S_RUN) && cpu_we && (cpu_addr == ADDR_W'(WATCH_ADDR));

  // Watched-address mirror and strobe; value survives reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_watch_data <= '0;
      r_watch_stb  <= 1'b0;
    end else begin
      r_watch_stb <= w_watch_hit;
      if (w_watch_hit) r_watch_data <= cpu_wdata;
    end
  end

`ifdef BOOT_RAM_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              w_enter_load;

  assign w_enter_load = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);

  // Modular sum of accepted load words, cleared on each new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_sum <= '0;
    else if (w_enter_load) r_sum <= '0;
    else if (w_hs)         r_sum <= r_sum + ld_data;
  end

  assign ld_sum = r_sum;
`else
  assign ld_sum = '0;
`endif

  assign cpu_rdata  = r_rdata;
  assign cpu_rst    = r_cpu_rst;
  assign ld_ready   = r_ld_ready;
  assign watch_data = r_watch_data;
  assign watch_stb  = r_watch_stb;

endmodule

// File: tb/tb_boot_ram.sv
// Directed self-checking bench for boot_ram (default parameters).
module tb_boot_ram;

  logic        clk;
  logic        rst;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_rst;
  logic        ld_start;
  logic [13:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [7:0]  watch_data;
  logic        watch_stb;
  logic [7:0]  ld_sum;

`ifdef BOOT_RAM_CHECKSUM_EN
  localparam logic [7:0] SUM_FF02 = 8'h01;
`else
  localparam logic [7:0] SUM_FF02 = 8'h00;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] words [16];
  int acc;
  int k;

  boot_ram dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_rst(cpu_rst),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .watch_data(watch_data), .watch_stb(watch_stb), .ld_sum(ld_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word_at(input int i, input int mode);
    if (mode == 0) return words[4'(i)];
    return 8'(i) ^ 8'h5C;
  endfunction

  // Start a load and stream up to nwords; stops when ld_ready drops after some accepts.
  task automatic do_load(input logic [13:0] len, input int nwords, input int mode, output int accepted);
    int cyc;
    accepted = 0;
    cyc = 0;
    ld_len   = len;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    while (accepted < nwords && cyc < 10000) begin
      if (!ld_ready && accepted > 0) break;
      ld_valid = 1'b1;
      ld_data  = word_at(accepted, mode);
      if (ld_ready) accepted++;
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    check("load_in_bound", 32'(cyc < 10000), 32'd1);
  endtask

  // Count samples with cpu_rst high before RUN.
  task automatic wait_run(output int cycles);
    cycles = 0;
    while (cpu_rst && cycles < 50) begin
      cycles++;
      tick();
    end
  endtask

  task automatic rd(input logic [12:0] a, input logic [7:0] exp, input string tag);
    cpu_addr = a;
    cpu_we   = 1'b0;
    tick();
    check(tag, 32'(cpu_rdata), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    repeat (3) tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_watch_data", 32'(watch_data), 32'd0);
    check("rst_watch_stb", 32'(watch_stb), 32'd0);
    check("rst_ld_sum", 32'(ld_sum), 32'd0);
    rst = 1'b0;
    tick();
    check("hold_cpu_rst", 32'(cpu_rst), 32'd1);

    // Basic three-word load
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_load(14'd3, 3, 0, acc);
    check("load3_accepted", 32'(acc), 32'd3);
    wait_run(k);
    check("load3_release_cycles", 32'(k), 32'd4);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    rd(13'd0, 8'h11, "rd_addr0");
    rd(13'd1, 8'h22, "rd_addr1");
    rd(13'd2, 8'h33, "rd_addr2");

    // Read-during-write returns old data
    cpu_addr = 13'd1; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    tick();
    check("rdw_old", 32'(cpu_rdata), 32'h22);
    cpu_we = 1'b0;
    tick();
    check("rdw_new", 32'(cpu_rdata), 32'h5A);

    // Watch address
    cpu_addr = 13'd100; cpu_wdata = 8'h37; cpu_we = 1'b1;
    tick();
    check("watch_stb_hit", 32'(watch_stb), 32'd1);
    check("watch_data_hit", 32'(watch_data), 32'h37);
    cpu_we = 1'b0;
    tick();
    check("watch_stb_single", 32'(watch_stb), 32'd0);
    cpu_addr = 13'd101; cpu_wdata = 8'h44; cpu_we = 1'b1;
    tick();
    check("watch_stb_101", 32'(watch_stb), 32'd0);
    check("watch_data_101", 32'(watch_data), 32'h37);
    cpu_addr = 13'd100; cpu_wdata = 8'h01;
    tick();
    check("watch_b2b_stb1", 32'(watch_stb), 32'd1);
    check("watch_b2b_data1", 32'(watch_data), 32'h01);
    cpu_wdata = 8'h02;
    tick();
    check("watch_b2b_stb2", 32'(watch_stb), 32'd1);
    check("watch_b2b_data2", 32'(watch_data), 32'h02);
    cpu_we = 1'b0;
    tick();
    check("watch_b2b_end", 32'(watch_stb), 32'd0);

    // Zero-length reload from RUN
    do_load(14'd0, 0, 0, acc);
    check("len0_cpu_rst", 32'(cpu_rst), 32'd1);
    check("len0_ld_ready", 32'(ld_ready), 32'd0);
    wait_run(k);
    check("len0_release_cycles", 32'(k), 32'd4);
    check("len0_watch_kept", 32'(watch_data), 32'h02);
    rd(13'd1, 8'h5A, "len0_mem_kept");

    // Async reset in the middle of a load
    words[0] = 8'hC1; words[1] = 8'hC2; words[2] = 8'hC3; words[3] = 8'hC4; words[4] = 8'hC5;
    do_load(14'd5, 2, 0, acc);
    check("partial_accepted", 32'(acc), 32'd2);
    check("partial_ld_ready", 32'(ld_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_watch_clr", 32'(watch_data), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("midrst_hold_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_hold_ready", 32'(ld_ready), 32'd0);
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    do_load(14'd3, 3, 0, acc);
    check("reload_accepted", 32'(acc), 32'd3);
    wait_run(k);
    check("reload_release_cycles", 32'(k), 32'd4);
    rd(13'd0, 8'hA1, "reload_addr0");
    rd(13'd2, 8'hA3, "reload_addr2");

    // Reload from RUN with checksum image
    words[0] = 8'hFF; words[1] = 8'h02;
    do_load(14'd2, 2, 0, acc);
    check("runload_cpu_rst", 32'(cpu_rst), 32'd1);
    wait_run(k);
    check("runload_release_cycles", 32'(k), 32'd4);
    check("ld_sum_ff02", 32'(ld_sum), 32'(SUM_FF02));
    rd(13'd0, 8'hFF, "runload_addr0");
    rd(13'd2, 8'hA3, "runload_addr2_kept");

    // Oversized length saturates at DEPTH
    do_load(14'd8193, 8193, 1, acc);
    check("sat_accepted", 32'(acc), 32'd8192);
    wait_run(k);
    check("sat_release_cycles", 32'(k), 32'd4);
    check("sat_ld_sum", 32'(ld_sum), 32'd0);
    rd(13'd8191, 8'hA3, "sat_last_addr");
    rd(13'd8190, 8'hA2, "sat_addr8190");
    rd(13'd0, 8'h5C, "sat_addr0");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
